ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/ex_muldiv_step.sv | 42 ++++
 rtl/ex_muldiv.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// op encodings, FSM state type, iteration count and a magnitude helper.
package ex_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    localparam int ITER = 32;
    localparam int CW   = $clog2(ITER);

    // Two's-complement magnitude when the operand is treated as negative.
    function automatic logic [31:0] mag(input logic [31:0] v,
                                        input logic        neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the multiply/divide datapath (combinational).
// Ports: div selects restoring divide step, acc/q state in, b operand,
//        acc_n/q_n next state.
module muldiv_step
    import ex_muldiv_pkg::*;
(
    input  logic        div,
    input  logic [31:0] acc,
    input  logic [31:0] q,
    input  logic [31:0] b,
    output logic [31:0] acc_n,
    output logic [31:0] q_n
);

    logic [32:0] sum;
    logic [32:0] trial;

    always_comb begin
        sum   = '0;
        trial = '0;
        acc_n = acc;
        q_n   = q;
        if (div) begin
            // Remainder stays below the divisor, so 33 bits hold the
            // shifted partial remainder; bit 32 is the borrow.
            trial = {acc, q[31]} - {1'b0, b};
            if (!trial[32]) begin
                acc_n = trial[31:0];
                q_n   = {q[30:0], 1'b1};
            end else begin
                acc_n = {acc[30:0], q[31]};
                q_n   = {q[30:0], 1'b0};
            end
        end else begin
            // Shift-add: multiplier bits leave q[0] as product bits enter.
            sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : 33'd0);
            acc_n = sum[32:1];
            q_n   = {sum[0], q[31:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit with HI/LO result registers.
// Ports: clock, reset, start/op/DataA/DataB request, mf_req, flush;
//        busy, stall, done, hi, lo.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] DataA,
    input  logic [31:0] DataB,
    input  logic        mf_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state, nstate;
    logic [CW-1:0] count;
    logic [31:0] acc, q, b_r, a_r;
    logic [31:0] acc_n, q_n;
    logic        div_r, neg_q, neg_r, dz;
    logic        last, accept;
    logic        is_div, sgn, sa, sb;
    logic [63:0] prod, prod_s;
    logic [31:0] hi_fin, lo_fin;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign sa     = sgn & DataA[31];
    assign sb     = sgn & DataB[31];

    assign last   = (state == S_RUN) && (count == CW'(ITER - 1));
    assign accept = (state == S_IDLE) && start && !flush;

    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
    assign stall = busy & (start | mf_req);

    muldiv_step u_step (
        .div   (div_r),
        .acc   (acc),
        .q     (q),
        .b     (b_r),
        .acc_n (acc_n),
        .q_n   (q_n)
    );

    // Sign fix-up on the final step's output; divide by zero bypasses it.
    always_comb begin
        prod   = {acc_n, q_n};
        prod_s = neg_q ? (~prod + 64'd1) : prod;
        hi_fin = prod_s[63:32];
        lo_fin = prod_s[31:0];
        if (div_r) begin
            if (dz) begin
                hi_fin = a_r;
                lo_fin = '1;
            end else begin
                hi_fin = mag(acc_n, neg_r);
                lo_fin = mag(q_n, neg_q);
            end
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE: if (accept) nstate = S_RUN;
            S_RUN: begin
                if (flush)     nstate = S_IDLE;
                else if (last) nstate = S_DONE;
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            acc   <= '0;
            q     <= '0;
            b_r   <= '0;
            a_r   <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            count <= '0;
            acc   <= '0;
            q     <= mag(DataA, sa);
            b_r   <= mag(DataB, sb);
            a_r   <= DataA;
            div_r <= is_div;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz    <= is_div && (DataB == 32'd0);
        end else if (state == S_RUN && !flush) begin
            count <= count + 1'b1;
            acc   <= acc_n;
            q     <= q_n;
            if (last) begin
                hi <= hi_fin;
                lo <= lo_fin;
            end
        end
    end

endmodule
